// File: rtl/nios2_mul_combine.sv
// rtl/nios2_mul_combine.sv - two-stage combiner of 16x16 partial products into the low word of a 32x32 product
module nios2_mul_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      done_count
);

    // Stage A: low partial product plus pre-summed cross terms
    logic             a_valid_q, a_valid_d;
    logic [31:0]      a_p1_q, a_p1_d;
    logic [15:0]      a_cross_q, a_cross_d;
    logic [TAG_W-1:0] a_tag_q, a_tag_d;

    // Stage B: final result, drives the outputs directly
    logic             b_valid_q, b_valid_d;
    logic [31:0]      b_result_q, b_result_d;
    logic [TAG_W-1:0] b_tag_q, b_tag_d;

    logic [15:0]      done_count_q, done_count_d;

    logic adv_b;
    logic adv_a;
    logic accept;
    logic move_ab;
    logic handoff;

    // Handshake: a stage may take new data when it is empty or its content moves on
    always_comb begin
        adv_b    = !b_valid_q || out_ready;
        adv_a    = !a_valid_q || adv_b;
        in_ready = adv_a && !flush;
        accept   = in_valid && in_ready;
        move_ab  = a_valid_q && adv_b;
        handoff  = b_valid_q && out_ready;
    end

    // Next-state for stage A; only the upper cross-term bits that land below bit 32 are kept
    always_comb begin
        a_valid_d = a_valid_q;
        a_p1_d    = a_p1_q;
        a_cross_d = a_cross_q;
        a_tag_d   = a_tag_q;
        if (adv_a) begin
            a_valid_d = accept;
        end
        if (accept) begin
            a_p1_d    = in_p1;
            a_cross_d = in_p2[15:0] + in_p3[15:0];
            a_tag_d   = in_tag;
        end
        if (flush) begin
            a_valid_d = 1'b0;
        end
    end

    // Next-state for stage B; carry out of bit 31 is dropped by the 32-bit add
    always_comb begin
        b_valid_d  = b_valid_q;
        b_result_d = b_result_q;
        b_tag_d    = b_tag_q;
        if (adv_b) begin
            b_valid_d = a_valid_q;
        end
        if (move_ab) begin
            b_result_d = a_p1_q + {a_cross_q, 16'h0000};
            b_tag_d    = a_tag_q;
        end
        if (flush) begin
            b_valid_d = 1'b0;
        end
    end

    // Completed-operation counter; a handoff during flush still counts
    always_comb begin
        done_count_d = done_count_q + {15'd0, handoff};
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid_q    <= 1'b0;
            a_p1_q       <= '0;
            a_cross_q    <= '0;
            a_tag_q      <= '0;
            b_valid_q    <= 1'b0;
            b_result_q   <= '0;
            b_tag_q      <= '0;
            done_count_q <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_p1_q       <= a_p1_d;
            a_cross_q    <= a_cross_d;
            a_tag_q      <= a_tag_d;
            b_valid_q    <= b_valid_d;
            b_result_q   <= b_result_d;
            b_tag_q      <= b_tag_d;
            done_count_q <= done_count_d;
        end
    end

    assign out_valid  = b_valid_q;
    assign out_result = b_result_q;
    assign out_tag    = b_tag_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_nios2_mul_combine.sv
// tb/tb_nios2_mul_combine.sv - scoreboard bench for nios2_mul_combine
module tb_nios2_mul_combine;

    localparam int TAG_W = 5;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_p1;
    logic [31:0]      in_p2;
    logic [31:0]      in_p3;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      done_count;

    nios2_mul_combine #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0]      exp_count = 16'd0;
    logic             stall_prev = 1'b0;
    logic [31:0]      prev_result;
    logic [TAG_W-1:0] prev_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard compare, handoff count model, stall stability
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            exp_count  = 16'd0;
            stall_prev = 1'b0;
        end else begin
            exp_t e;
            check("done_count", {16'd0, done_count}, {16'd0, exp_count});
            if (stall_prev) begin
                check("stall_result", out_result, prev_result);
                check("stall_tag", {27'd0, out_tag}, {27'd0, prev_tag});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.result);
                    check("tag", {27'd0, out_tag}, {27'd0, e.tag});
                end
                exp_count = exp_count + 16'd1;
            end
            if (flush) sb.delete();
            stall_prev  = out_valid && !out_ready && !flush;
            prev_result = out_result;
            prev_tag    = out_tag;
        end
    end

    // Offer one operation and hold it until accepted; leaves in_valid high
    task automatic send_raw(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp_res);
        bit   done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        in_p1    = p1;
        in_p2    = p2;
        in_p3    = p3;
        in_tag   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.result = exp_res;
                e.tag    = tag;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic [31:0] p1, p2, p3, prod;
        p1   = {16'd0, a[15:0]} * {16'd0, b[15:0]};
        p2   = {16'd0, a[15:0]} * {16'd0, b[31:16]};
        p3   = {16'd0, a[31:16]} * {16'd0, b[15:0]};
        prod = a * b;
        send_raw(p1, p2, p3, tag, prod);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c0;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_p1     = '0;
        in_p2     = '0;
        in_p3     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        wait_cycles(2);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);
        check("rst_done_count", {16'd0, done_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic op with latency check
        send_raw(32'h00000008, 32'h0000000A, 32'h0000000C, 5'd3, 32'h00160008);
        idle();
        check("lat_not_yet", {31'd0, out_valid}, 32'd0);
        wait_cycles(1);
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("basic_result", out_result, 32'h00160008);
        wait_cycles(1);
        check("basic_count", {16'd0, done_count}, 32'd1);

        // Wrap and ignored upper halves
        send_raw(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd1, 32'h00000001);
        send_raw(32'h00000000, 32'h12340000, 32'h56780000, 5'd2, 32'h00000000);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        idle();
        wait_cycles(3);

        // Streaming: 8 back-to-back at full rate
        c0 = cyc;
        for (int i = 0; i < 8; i++) send($urandom, $urandom, i[TAG_W-1:0]);
        check("stream_cycles", cyc - c0, 32'd8);
        idle();
        wait_cycles(3);
        check("stream_count", {16'd0, done_count}, 32'd12);
        check("stream_drained", sb.size(), 32'd0);

        // Backpressure: two held, third blocked, then resume
        out_ready = 1'b0;
        send($urandom, $urandom, 5'd10);
        send($urandom, $urandom, 5'd11);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        fork
            begin
                send($urandom, $urandom, 5'd12);
                send($urandom, $urandom, 5'd13);
                idle();
            end
            begin
                wait_cycles(3);
                out_ready = 1'b1;
            end
        join
        wait_cycles(4);
        check("bp_count", {16'd0, done_count}, 32'd16);
        check("bp_drained", sb.size(), 32'd0);

        // Flush with two in flight and stalled output
        out_ready = 1'b0;
        send($urandom, $urandom, 5'd20);
        send($urandom, $urandom, 5'd21);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_p1    = 32'h1111_1111;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_count", {16'd0, done_count}, 32'd16);
        out_ready = 1'b1;
        send($urandom, $urandom, 5'd22);
        idle();
        check("post_flush_lat0", {31'd0, out_valid}, 32'd0);
        wait_cycles(1);
        check("post_flush_lat1", {31'd0, out_valid}, 32'd1);
        wait_cycles(2);

        // Reset mid-stream with B stalled
        out_ready = 1'b0;
        send($urandom, $urandom, 5'd25);
        send($urandom, $urandom, 5'd26);
        idle();
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_tag", {27'd0, out_tag}, 32'd0);
        check("mid_rst_count", {16'd0, done_count}, 32'd0);
        out_ready = 1'b1;
        wait_cycles(1);

        // Counter wrap
        for (int i = 0; i < 65535; i++) send($urandom, $urandom, i[TAG_W-1:0]);
        idle();
        wait_cycles(3);
        check("count_ffff", {16'd0, done_count}, 32'h0000FFFF);
        send(32'd7, 32'd9, 5'd31);
        idle();
        wait_cycles(3);
        check("count_wrap", {16'd0, done_count}, 32'd0);
        check("final_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
